decode_stage_vp: RTL
====================

Name: decode_stage_vp

Overview:
Parametrised vector decode stage for the vector pipeline. It decodes a 26-bit instruction and reads two operands from a LANES x LANE_W register file. It tracks in-flight writes with a per-register scoreboard to stall on RAW hazards, and registers the decoded bundle into a valid/ready decode-to-execute pipeline register. It sits between fetch and execute and receives writeback from the W stage.

Parameters:
LANES, 8, number of vector lanes
LANE_W, 32, bits per lane (min 32); VW = LANES*LANE_W is derived
SB_W, 2, width of each scoreboard pending counter (max 2^SB_W-1 in-flight writes per register)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  fetch presents inst_d
in_ready  out  1  decode consumes inst_d this cycle
inst_d  in  26  [25]cond [24:23]opcode [22:17]funct [16:14]rs1 [13:11]rd [2:0]rs2 [20:0]imm
pc_plus8  in  32  value read for register 7
in_flags  in  4  NZCV captured with the instruction
wb_we  in  1  writeback enable
wb_addr  in  3  writeback register
wb_data  in  VW  writeback data
flush_e  in  1  kill E register contents and the instruction in decode
out_valid  out  1  E bundle valid
out_ready  in  1  execute accepts the bundle
rd1_e, rd2_e, ext_imm_e  out  VW  operands and extended immediate
wa3_e, ra1_e, ra2_e  out  3  dest/source indices
reg_write_e, mem_to_reg_e, mem_write_e, branch_e, alu_src_e, pc_src_e, cond_e  out  1  controls
alu_ctrl_e  out  3  ALU op
flag_write_e  out  2  flag update enables
flags_e  out  4  captured flags
stall_d  out  1  RAW/scoreboard stall active

Behaviour:
- Reset (synchronous): all E outputs 0, out_valid=0, all registers 0, all counters 0.
- Decode, opcode 00 ALU:
  - reg_write=1, alu_src=funct[5], alu_ctrl=funct[3:1], flag_write={2{funct[0]}}, pc_src=(rd==7).
  - ra1=rs1, ra2=rs2.
  - ext = imm[7:0] zero-extended to LANE_W, replicated in every lane.
- Decode, opcode 01 MEM:
  - alu_src=1, alu_ctrl=000, ra1=rs1.
  - funct[0]=1 is a load: reg_write=1, mem_to_reg=1.
  - funct[0]=0 is a store: mem_write=1, ra2=rd.
  - ext = imm[11:0] zero-extended into lane 0; other lanes 0.
- Decode, opcode 10 BRANCH:
  - branch=1, alu_src=1, alu_ctrl=000, ra1=7.
  - ext = sign-extended {imm,2'b00} into lane 0; other lanes 0.
- Decode, opcode 11: NOP. All controls 0.
- Register file reads are combinational with write-first bypass: wb_we && wb_addr==ra returns wb_data. Reg 7 reads return pc_plus8 zero-extended in lane 0, other lanes 0. wb_addr==7 writes are ignored.
- Hazard on a used source r (r!=7): cnt[r]!=0 and not (wb_we && wb_addr==r && cnt[r]==1).
- Saturation stall: reg_write && rd!=7 && cnt[rd]==max.
- stall_d = in_valid && (hazard || saturation) && !flush_e.
- in_ready = flush_e || (!stall_d && (!out_valid || out_ready)).
- issue = in_valid && in_ready && !flush_e.
- E register:
  - flush_e: out_valid<=0 and controls cleared; the decode instruction is consumed and dropped.
  - Else if (!out_valid || out_ready): out_valid<=issue, bundle loaded on issue. A bubble clears all controls.
  - Else: hold all E outputs. Latency is 1 cycle from issue to out_valid.
- Scoreboard: cnt[r] += inc - dec_wb - dec_fl, clamped to [0, max]. All three terms may occur in the same cycle.
  - inc = issue && reg_write_d && rd==r && r!=7.
  - dec_wb = wb_we && wb_addr==r.
  - dec_fl = flush_e && out_valid && reg_write_e && wa3_e==r.
- flags_e and cond_e load from in_flags and inst_d[25] on issue.

Optional Feature:
LANE_MASK_EN.
- Defined: adds port wb_mask (in, LANES). Only lanes whose mask bit is 1 are written. Bypass merges per lane: masked lanes come from wb_data, the rest from stored data. The scoreboard decrements regardless of mask.
- Undefined: no port; all lanes are written.

Test Plan:
- Reset, then ALU rd=3 rs1=1 rs2=2 with r1=r2=0 -> next cycle out_valid=1, reg_write_e=1, wa3_e=3, rd1_e=0, cnt[3]=1.
- Issue a writer to r3, then a reader of r3 while no writeback is pending -> stall_d=1, in_ready=0. Then wb_we with wb_addr=3, wb_data=all 0xA5 -> same cycle stall_d=0, next rd1_e=0xA5 in every lane, cnt[3]=0.
- out_ready=0 for 3 cycles with in_valid=1 -> E outputs held, in_ready=0; out_ready=1 -> next instruction issues the following cycle.
- flush_e while E holds a writer to r5 (cnt[5]=1) and decode holds a writer to r5 -> out_valid=0, cnt[5]=0, in_ready=1.
- SB_W=2: three writers to r4 with no writeback -> fourth writer stalls (cnt=3). Simultaneous issue and writeback on r4 -> cnt unchanged.
- Branch imm=21'h1FFFFF, rs1 ignored -> ext_imm_e lane 0 = -4, rd1_e lane 0 = pc_plus8.

Source files
------------

// File: rtl/decode_stage_vp.sv
// decode_stage_vp: vector decode stage. It decodes a 26-bit instruction and reads two
// LANES x LANE_W operands with write-first bypass. A per-register pending-write scoreboard
// stalls the stage on RAW hazards, and the decoded bundle goes into a valid/ready E register.
// Optional feature: define LANE_MASK_EN to add the wb_mask input, which gives per-lane
// writeback enables.
module decode_stage_vp #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned SB_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [25:0]             inst_d,
  input  logic [31:0]             pc_plus8,
  input  logic [3:0]              in_flags,
  input  logic                    wb_we,
  input  logic [2:0]              wb_addr,
  input  logic [LANES*LANE_W-1:0] wb_data,
`ifdef LANE_MASK_EN
  input  logic [LANES-1:0]        wb_mask,
`endif
  input  logic                    flush_e,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] rd1_e,
  output logic [LANES*LANE_W-1:0] rd2_e,
  output logic [LANES*LANE_W-1:0] ext_imm_e,
  output logic [2:0]              wa3_e,
  output logic [2:0]              ra1_e,
  output logic [2:0]              ra2_e,
  output logic                    reg_write_e,
  output logic                    mem_to_reg_e,
  output logic                    mem_write_e,
  output logic                    branch_e,
  output logic                    alu_src_e,
  output logic                    pc_src_e,
  output logic                    cond_e,
  output logic [2:0]              alu_ctrl_e,
  output logic [1:0]              flag_write_e,
  output logic [3:0]              flags_e,
  output logic                    stall_d
);

  localparam int unsigned VW      = LANES * LANE_W;
  localparam int          NREG    = 8;
  localparam int unsigned CNT_MAX = (1 << SB_W) - 1;

  // Instruction fields (imm overlaps the other fields by design)
  logic        cond_d;
  logic [1:0]  opcode;
  logic [5:0]  funct;
  logic [2:0]  rs1;
  logic [2:0]  rd;
  logic [2:0]  rs2;
  logic [20:0] imm;
  logic        unused_funct4;

  assign cond_d        = inst_d[25];
  assign opcode        = inst_d[24:23];
  assign funct         = inst_d[22:17];
  assign rs1           = inst_d[16:14];
  assign rd            = inst_d[13:11];
  assign rs2           = inst_d[2:0];
  assign imm           = inst_d[20:0];
  assign unused_funct4 = funct[4];

  // Immediate lane forms
  logic [LANE_W-1:0] imm8_lane;
  logic [LANE_W-1:0] br_lane;

  assign imm8_lane = LANE_W'(imm[7:0]);
  assign br_lane   = {{(LANE_W-23){imm[20]}}, imm, 2'b00};

  // Decoded controls
  logic          reg_write_d;
  logic          mem_to_reg_d;
  logic          mem_write_d;
  logic          branch_d;
  logic          alu_src_d;
  logic          pc_src_d;
  logic [2:0]    alu_ctrl_d;
  logic [1:0]    flag_write_d;
  logic [2:0]    ra1_d;
  logic [2:0]    ra2_d;
  logic          use1_d;
  logic          use2_d;
  logic [VW-1:0] ext_d;

  // Register file and scoreboard state
  logic [VW-1:0]   regs    [NREG];
  logic [SB_W-1:0] cnt     [NREG];
  logic [SB_W-1:0] cnt_nxt [NREG];

  logic [VW-1:0]   wb_bits;
  logic [VW-1:0]   rd1_d;
  logic [VW-1:0]   rd2_d;
  logic [NREG-1:0] busy;
  logic            hazard;
  logic            sat;
  logic            issue;
  logic            e_en;

  // Instruction decode; source-use flags mark which operands can create a RAW hazard
  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    pc_src_d     = 1'b0;
    alu_ctrl_d   = 3'b000;
    flag_write_d = 2'b00;
    ra1_d        = 3'd0;
    ra2_d        = 3'd0;
    use1_d       = 1'b0;
    use2_d       = 1'b0;
    ext_d        = '0;
    case (opcode)
      2'b00: begin
        reg_write_d  = 1'b1;
        alu_src_d    = funct[5];
        alu_ctrl_d   = funct[3:1];
        flag_write_d = {2{funct[0]}};
        pc_src_d     = (rd == 3'd7);
        ra1_d        = rs1;
        ra2_d        = rs2;
        use1_d       = 1'b1;
        use2_d       = !funct[5];
        ext_d        = {LANES{imm8_lane}};
      end
      2'b01: begin
        alu_src_d = 1'b1;
        ra1_d     = rs1;
        use1_d    = 1'b1;
        ext_d     = VW'(imm[11:0]);
        if (funct[0]) begin
          reg_write_d  = 1'b1;
          mem_to_reg_d = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          ra2_d       = rd;
          use2_d      = 1'b1;
        end
      end
      2'b10: begin
        branch_d  = 1'b1;
        alu_src_d = 1'b1;
        ra1_d     = 3'd7;
        ext_d     = VW'(br_lane);
      end
      default: ;
    endcase
  end

`ifdef LANE_MASK_EN
  // Expand the per-lane writeback mask to a bit mask
  always_comb begin
    wb_bits = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      wb_bits[l*LANE_W +: LANE_W] = {LANE_W{wb_mask[l]}};
    end
  end
`else
  assign wb_bits = '1;
`endif

  // Operand reads: r7 gives the PC, a same-cycle writeback bypasses the stored value
  always_comb begin
    if (ra1_d == 3'd7) begin
      rd1_d = VW'(pc_plus8);
    end else if (wb_we && (wb_addr == ra1_d)) begin
      rd1_d = (wb_data & wb_bits) | (regs[ra1_d] & ~wb_bits);
    end else begin
      rd1_d = regs[ra1_d];
    end
    if (ra2_d == 3'd7) begin
      rd2_d = VW'(pc_plus8);
    end else if (wb_we && (wb_addr == ra2_d)) begin
      rd2_d = (wb_data & wb_bits) | (regs[ra2_d] & ~wb_bits);
    end else begin
      rd2_d = regs[ra2_d];
    end
  end

  // A register is busy when writes are pending, unless its last one retires this cycle
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG - 1; r++) begin
      busy[r] = (cnt[r] != '0) &&
                !(wb_we && (wb_addr == 3'(r)) && (cnt[r] == SB_W'(1)));
    end
  end

  // Stall and handshake
  always_comb begin
    hazard   = (use1_d && busy[ra1_d]) || (use2_d && busy[ra2_d]);
    sat      = reg_write_d && (rd != 3'd7) && (cnt[rd] == SB_W'(CNT_MAX));
    stall_d  = in_valid && (hazard || sat) && !flush_e;
    in_ready = flush_e || (!stall_d && (!out_valid || out_ready));
    issue    = in_valid && in_ready && !flush_e;
    e_en     = flush_e || !out_valid || out_ready;
  end

  // Saturating update of one pending-write counter
  function automatic logic [SB_W-1:0] sb_next(input logic [SB_W-1:0] c, input logic inc,
                                              input logic dec_wb, input logic dec_fl);
    int t;
    t = int'(c) + int'(inc) - int'(dec_wb) - int'(dec_fl);
    if (t < 0) t = 0;
    if (t > int'(CNT_MAX)) t = int'(CNT_MAX);
    return SB_W'(t);
  endfunction

  // Scoreboard next state: issue increments, writeback and flushed E writers decrement
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = sb_next(cnt[r],
                           issue && reg_write_d && (rd == 3'(r)) && (r != NREG - 1),
                           wb_we && (wb_addr == 3'(r)),
                           flush_e && out_valid && reg_write_e && (wa3_e == 3'(r)));
    end
  end

  // Scoreboard counters
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) cnt[r] <= '0;
      else       cnt[r] <= cnt_nxt[r];
    end
  end

  // Register file write; r7 is the PC and is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_we && (wb_addr != 3'd7)) begin
      regs[wb_addr] <= (wb_data & wb_bits) | (regs[wb_addr] & ~wb_bits);
    end
  end

  // E pipeline register: load on issue, clear on bubble or flush, hold under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      ext_imm_e    <= '0;
      wa3_e        <= '0;
      ra1_e        <= '0;
      ra2_e        <= '0;
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      mem_write_e  <= 1'b0;
      branch_e     <= 1'b0;
      alu_src_e    <= 1'b0;
      pc_src_e     <= 1'b0;
      cond_e       <= 1'b0;
      alu_ctrl_e   <= '0;
      flag_write_e <= '0;
      flags_e      <= '0;
    end else if (e_en) begin
      out_valid    <= issue;
      rd1_e        <= issue ? rd1_d : '0;
      rd2_e        <= issue ? rd2_d : '0;
      ext_imm_e    <= issue ? ext_d : '0;
      wa3_e        <= issue ? rd : '0;
      ra1_e        <= issue ? ra1_d : '0;
      ra2_e        <= issue ? ra2_d : '0;
      reg_write_e  <= issue && reg_write_d;
      mem_to_reg_e <= issue && mem_to_reg_d;
      mem_write_e  <= issue && mem_write_d;
      branch_e     <= issue && branch_d;
      alu_src_e    <= issue && alu_src_d;
      pc_src_e     <= issue && pc_src_d;
      cond_e       <= issue && cond_d;
      alu_ctrl_e   <= issue ? alu_ctrl_d : '0;
      flag_write_e <= issue ? flag_write_d : '0;
      flags_e      <= issue ? in_flags : '0;
    end
  end

endmodule
